// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC1/EXEC2 sequencer for the MIPS core: phase strobes, bus handshake, PC timing, halt.
// Optional bus-stall watchdog enabled by defining CPU_SEQ_TIMEOUT_EN.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waitrequest,
  input  logic [6:0] instruction_code,
  input  logic       pc_zero,
  input  logic       muldiv_done,
  output logic       fetch,
  output logic       exec1,
  output logic       exec2,
  output logic       active,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write_en,
  output logic       stall,
  output logic       timeout_err
);

  // state    | meaning
  // S_FETCH  | instruction read on the bus
  // S_EXEC1  | decode/ALU phase, data access for loads/stores
  // S_EXEC2  | writeback for load/lui/link, wait for mul/div result
  // S_HALTED | stopped; only reset leaves
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC1  = 2'd1,
    S_EXEC2  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic is_load, is_lui, is_store, is_link, is_muldiv;
  logic bus_wait, muldiv_wait, two_phase;

  // Out-of-range values leave the watchdog compare meaningless; the guard keeps the parameter referenced.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
  end

  always_comb begin
    is_load   = (instruction_code >= 7'd42) && (instruction_code <= 7'd49) && (instruction_code != 7'd46);
    is_lui    = (instruction_code == 7'd46);
    is_store  = (instruction_code >= 7'd50) && (instruction_code <= 7'd52);
    is_link   = (instruction_code == 7'd32) || (instruction_code == 7'd36) ||
                (instruction_code == 7'd39) || (instruction_code == 7'd40);
    is_muldiv = (instruction_code == 7'd7)  || (instruction_code == 7'd8) ||
                (instruction_code == 7'd13) || (instruction_code == 7'd14);
    two_phase = is_load | is_lui | is_link | is_muldiv;
  end

  assign fetch  = (state_q == S_FETCH);
  assign exec1  = (state_q == S_EXEC1);
  assign exec2  = (state_q == S_EXEC2);
  assign active = (state_q != S_HALTED);

  always_comb begin
    mem_read    = (fetch && !pc_zero) || (exec1 && is_load);
    mem_write   = exec1 && is_store;
    bus_wait    = (mem_read | mem_write) & waitrequest;
    muldiv_wait = exec2 && is_muldiv && !muldiv_done;
    stall       = bus_wait | muldiv_wait;
    pc_write_en = (exec1 && !bus_wait && !two_phase) || (exec2 && !muldiv_wait);
  end

  logic timeout_hit;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       timeout_err_q, timeout_err_d;

  always_comb begin
    timeout_hit   = stall && (stall_cnt_q == TO_LAST);
    stall_cnt_d   = stall ? stall_cnt_q + 8'd1 : 8'd0;
    timeout_err_d = timeout_err_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q   <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (pc_zero)           state_d = S_HALTED;
        else if (!waitrequest) state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (!bus_wait) state_d = two_phase ? S_EXEC2 : S_FETCH;
      end
      S_EXEC2: begin
        if (!muldiv_wait) state_d = S_FETCH;
      end
      default: state_d = S_HALTED;
    endcase
    if (timeout_hit) state_d = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

endmodule
